// File: rtl/matrix_operand_loader_if.sv
// Byte-stream input and packed-operand output bundle of the matrix operand loader.
interface matrix_operand_loader_if #(
  parameter int unsigned ELEM_W = 8,
  parameter int unsigned N_ELEM = 4
);
  logic [ELEM_W-1:0]        in_data;
  logic                     in_valid;
  logic                     in_ready;
  logic                     op_in;
  logic                     clear;
  logic [2:0]               load_idx;
  logic [ELEM_W*N_ELEM-1:0] A;
  logic [ELEM_W*N_ELEM-1:0] B;
  logic                     op_out;
  logic                     out_valid;
  logic                     out_ready;

  modport master (
    output in_data, in_valid, op_in, clear, out_ready,
    input  in_ready, load_idx, A, B, op_out, out_valid
  );

  modport slave (
    input  in_data, in_valid, op_in, clear, out_ready,
    output in_ready, load_idx, A, B, op_out, out_valid
  );
endinterface

// File: rtl/matrix_operand_loader.sv
// Assembles 2x2 matrices A and B from a byte stream and presents them atomically
// with the operation select over a valid/ready handshake.
module matrix_operand_loader #(
  parameter int unsigned ELEM_W = 8,
  parameter int unsigned N_ELEM = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  matrix_operand_loader_if.slave  bus
);
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned SLOT_W = $clog2(N_ELEM);
  localparam int unsigned MAT_W  = ELEM_W * N_ELEM;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(2 * N_ELEM - 1);

  typedef enum logic [0:0] {LOAD = 1'b0, HOLD = 1'b1} state_t;

  state_t                          state_q, state_d;
  logic [IDX_W-1:0]                idx_q, idx_d;
  logic [N_ELEM-1:0][ELEM_W-1:0]   stage_a_q, stage_b_q, stage_b_c;
  logic [MAT_W-1:0]                a_q, b_q;
  logic                            op_q;
  logic                            in_ready_c, accept_c, done_c, is_b_c;
  logic [SLOT_W-1:0]               slot_c;

  // clear vetoes the accept so neither staging nor the counter move on that edge
  assign in_ready_c = (state_q == LOAD) && !rst;
  assign accept_c   = bus.in_valid && in_ready_c && !bus.clear;
  assign slot_c     = idx_q[SLOT_W-1:0];
  assign is_b_c     = idx_q[SLOT_W];
  assign done_c     = accept_c && (idx_q == LAST_IDX);

  // State and element counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (bus.clear) begin
      state_d = LOAD;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        LOAD: begin
          if (accept_c) begin
            idx_d = idx_q + IDX_W'(1);
            if (done_c) begin
              state_d = HOLD;
              idx_d   = '0;
            end
          end
        end
        HOLD: begin
          if (bus.out_ready) state_d = LOAD;
        end
        default: begin
          state_d = LOAD;
          idx_d   = '0;
        end
      endcase
    end
  end

  // B staging including the element arriving this cycle, for the completion copy
  always_comb begin
    stage_b_c         = stage_b_q;
    stage_b_c[slot_c] = bus.in_data;
  end

  // Staging and presented-operand registers
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_a_q <= '0;
      stage_b_q <= '0;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= 1'b0;
    end else begin
      if (accept_c) begin
        if (is_b_c) stage_b_q[slot_c] <= bus.in_data;
        else        stage_a_q[slot_c] <= bus.in_data;
      end
      if (done_c) begin
        a_q  <= stage_a_q;
        b_q  <= stage_b_c;
        op_q <= bus.op_in;
      end
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = (state_q == HOLD);
  assign bus.load_idx  = idx_q;
  assign bus.A         = a_q;
  assign bus.B         = b_q;
  assign bus.op_out    = op_q;
endmodule

// File: tb/tb_matrix_operand_loader.sv
// Directed bench for matrix_operand_loader: a beat-list model checked every cycle
// plus literal expectations for each scenario.
module tb_matrix_operand_loader;
  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  matrix_operand_loader_if #(.ELEM_W(8), .N_ELEM(4)) bus ();

  matrix_operand_loader #(.ELEM_W(8), .N_ELEM(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: list of beats taken since the last set boundary, plus the presented set
  logic [7:0]  beats[$];
  logic        m_hold = 1'b0;
  logic [31:0] m_a = '0;
  logic [31:0] m_b = '0;
  logic        m_op = 1'b0;

  function automatic logic [31:0] pack4(input int off);
    logic [31:0] r;
    for (int k = 0; k < 4; k++) r[8*k +: 8] = beats[off + k];
    return r;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        beats.delete();
        m_hold = 1'b0;
        m_a = '0;
        m_b = '0;
        m_op = 1'b0;
      end else if (bus.clear) begin
        beats.delete();
        m_hold = 1'b0;
      end else if (m_hold) begin
        if (bus.out_ready) m_hold = 1'b0;
      end else if (bus.in_valid) begin
        beats.push_back(bus.in_data);
        if (beats.size() == 8) begin
          m_a = pack4(0);
          m_b = pack4(4);
          m_op = bus.op_in;
          beats.delete();
          m_hold = 1'b1;
        end
      end
    end
  end

  // Per-cycle comparison against the model, plus set-arrival recording
  logic        chk_en = 1'b0;
  logic        rec_on = 1'b0;
  logic        prev_ov = 1'b0;
  int          cyc = 0;
  int          rise_cyc[$];
  logic [31:0] rise_a[$];
  logic [31:0] rise_b[$];

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (chk_en) begin
        check("in_ready",  32'(bus.in_ready),  32'(!m_hold && !rst));
        check("out_valid", 32'(bus.out_valid), 32'(m_hold));
        check("load_idx",  32'(bus.load_idx),  32'(beats.size()));
        check("A",         bus.A,              m_a);
        check("B",         bus.B,              m_b);
        check("op_out",    32'(bus.op_out),    32'(m_op));
        if (rec_on && bus.out_valid && !prev_ov) begin
          rise_cyc.push_back(cyc);
          rise_a.push_back(bus.A);
          rise_b.push_back(bus.B);
        end
        prev_ov = bus.out_valid;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  logic [7:0] t1_bytes [8];
  logic [7:0] t4_bytes [8];
  logic [7:0] d;
  logic       was_ready;

  initial begin
    t1_bytes = '{8'h00, 8'h02, 8'h01, 8'h00, 8'h01, 8'h00, 8'h02, 8'h01};
    t4_bytes = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'h01, 8'h02, 8'h03, 8'h04};
    rst = 1'b1;
    bus.in_data = '0;
    bus.in_valid = 1'b0;
    bus.op_in = 1'b0;
    bus.clear = 1'b0;
    bus.out_ready = 1'b0;
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("reset_A", bus.A, 32'h0);
    check("reset_in_ready", 32'(bus.in_ready), 32'd1);
    #1;

    // Test 1: straight load, out_ready low
    bus.in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.in_data = t1_bytes[i];
      tick();
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("t1_A", bus.A, 32'h00010200);
    check("t1_B", bus.B, 32'h01020001);
    check("t1_op", 32'(bus.op_out), 32'd0);
    check("t1_out_valid", 32'(bus.out_valid), 32'd1);
    check("t1_in_ready", 32'(bus.in_ready), 32'd0);
    check("t1_load_idx", 32'(bus.load_idx), 32'd0);
    #1;

    // Test 2: wait in HOLD, then consume
    for (int i = 0; i < 5; i++) begin
      tick();
      @(negedge clk);
      check("t2_hold_valid", 32'(bus.out_valid), 32'd1);
      check("t2_hold_A", bus.A, 32'h00010200);
    end
    #1;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    @(negedge clk);
    check("t2_out_valid", 32'(bus.out_valid), 32'd0);
    check("t2_in_ready", 32'(bus.in_ready), 32'd1);
    check("t2_A", bus.A, 32'h00010200);
    check("t2_B", bus.B, 32'h01020001);
    #1;

    // Test 3: gapped input with op=sub
    bus.op_in = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus.in_valid = (i % 2 == 0);
      bus.in_data = 8'((i / 2 + 1) * 8'h11);
      tick();
      if (i == 4) check("t3_idx_mid", 32'(bus.load_idx), 32'd3);
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("t3_A", bus.A, 32'h44332211);
    check("t3_B", bus.B, 32'h88776655);
    check("t3_op", 32'(bus.op_out), 32'd1);
    #1;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;

    // Test 4: clear after 5 accepts, then a full reload
    bus.op_in = 1'b0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.in_data = 8'(i + 1);
      tick();
    end
    bus.clear = 1'b1;
    bus.in_data = 8'hEE;
    tick();
    bus.clear = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("t4_clear_idx", 32'(bus.load_idx), 32'd0);
    check("t4_clear_A", bus.A, 32'h44332211);
    check("t4_clear_B", bus.B, 32'h88776655);
    #1;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.in_data = t4_bytes[i];
      tick();
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("t4_A", bus.A, 32'hD4C3B2A1);
    check("t4_B", bus.B, 32'h04030201);
    check("t4_out_valid", 32'(bus.out_valid), 32'd1);
    #1;

    // Test 5: reset during HOLD with out_ready high
    bus.out_ready = 1'b1;
    rst = 1'b1;
    tick();
    @(negedge clk);
    check("t5_A", bus.A, 32'h0);
    check("t5_B", bus.B, 32'h0);
    check("t5_out_valid", 32'(bus.out_valid), 32'd0);
    check("t5_in_ready_rst", 32'(bus.in_ready), 32'd0);
    #1;
    rst = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    check("t5_in_ready_rel", 32'(bus.in_ready), 32'd1);
    #1;

    // Test 6: back-to-back sets, continuous valid and ready
    rec_on = 1'b1;
    d = 8'h10;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 29; i++) begin
      bus.in_data = d;
      was_ready = bus.in_ready;
      tick();
      if (was_ready) d = d + 8'd1;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    check("t6_sets", 32'(rise_cyc.size()), 32'd3);
    if (rise_cyc.size() >= 3) begin
      check("t6_period1", 32'(rise_cyc[1] - rise_cyc[0]), 32'd9);
      check("t6_period2", 32'(rise_cyc[2] - rise_cyc[1]), 32'd9);
      check("t6_A0", rise_a[0], 32'h13121110);
      check("t6_B0", rise_b[0], 32'h17161514);
      check("t6_A1", rise_a[1], 32'h1B1A1918);
      check("t6_B1", rise_b[1], 32'h1F1E1D1C);
      check("t6_A2", rise_a[2], 32'h23222120);
      check("t6_B2", rise_b[2], 32'h27262524);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
